// File: rtl/tlight_seq.sv
// tlight_seq: traffic-light phase sequencer timed in VGA frame ticks.
//
// Cycles RED -> GREEN -> YELLOW -> RED. Each phase lasts its *_FRAMES count of
// frame_tick_i pulses. Between ticks, state and counter hold.
//
// Optional feature (compile-time macro TLIGHT_PED_EN): pedestrian requests.
// A request can shorten GREEN to MIN_GREEN_FRAMES ticks. It then lights walk
// for the following RED phase.
//
// Ports:
//   clk_i           pixel clock, sole clock
//   reset_i         asynchronous active-high reset
//   frame_tick_i    one-cycle pulse per frame
//   ped_req_i       pedestrian request, any length (ignored without TLIGHT_PED_EN)
//   lamp_red_o      red lamp on
//   lamp_yel_o      yellow lamp on
//   lamp_grn_o      green lamp on
//   state_o         00 RED, 01 GREEN, 10 YELLOW
//   state_change_o  one-cycle pulse on the first cycle of a new state
//   walk_o          walk signal lit
//   ped_ack_o       one-cycle pulse when a pending request is granted
module tlight_seq #(
   parameter int RED_FRAMES       = 300,
   parameter int GREEN_FRAMES     = 300,
   parameter int YELLOW_FRAMES    = 120,
   parameter int MIN_GREEN_FRAMES = 60,
   parameter int CNT_BITS         = 10
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       frame_tick_i,
   input  logic       ped_req_i,
   output logic       lamp_red_o,
   output logic       lamp_yel_o,
   output logic       lamp_grn_o,
   output logic [1:0] state_o,
   output logic       state_change_o,
   output logic       walk_o,
   output logic       ped_ack_o
);

`ifdef TLIGHT_PED_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_RED = 2'b00,
      S_GRN = 2'b01,
      S_YEL = 2'b10
   } state_t;

   localparam logic [CNT_BITS-1:0] RED_LAST = CNT_BITS'(RED_FRAMES - 1);
   localparam logic [CNT_BITS-1:0] GRN_LAST = CNT_BITS'(GREEN_FRAMES - 1);
   localparam logic [CNT_BITS-1:0] YEL_LAST = CNT_BITS'(YELLOW_FRAMES - 1);
   localparam logic [CNT_BITS-1:0] MG_LAST  = CNT_BITS'(MIN_GREEN_FRAMES - 1);

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d, last;
   logic                ped_pend_q, ped_pend_d;
   logic [2:0]          lamp_q, lamp_d;
   logic                sc_q, sc_d, walk_q, walk_d, ack_q, ack_d;
   logic                adv, cut, grant;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_RED;
         cnt_q      <= '0;
         ped_pend_q <= 1'b0;
         lamp_q     <= 3'b100;
         sc_q       <= 1'b0;
         walk_q     <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ped_pend_q <= ped_pend_d;
         lamp_q     <= lamp_d;
         sc_q       <= sc_d;
         walk_q     <= walk_d;
         ack_q      <= ack_d;
      end
   end

   // Decisions use the registered pending flag, so a request seen on a tick
   // cycle only takes effect from the following tick.
   always_comb begin
      last       = state_q == S_RED ? RED_LAST : state_q == S_GRN ? GRN_LAST : YEL_LAST;
      cut        = PED_EN && state_q == S_GRN && ped_pend_q && cnt_q >= MG_LAST;
      adv        = frame_tick_i && (cnt_q == last || cut);
      state_d    = !adv ? state_q : state_q == S_RED ? S_GRN : state_q == S_GRN ? S_YEL : S_RED;
      cnt_d      = adv ? '0 : frame_tick_i ? cnt_q + 1'b1 : cnt_q;
      grant      = adv && state_q == S_YEL && ped_pend_q;
      ped_pend_d = PED_EN && (ped_req_i || (ped_pend_q && !grant));
   end

   // Walk is decided on entry to RED and holds until the next transition.
   // Leaving RED never grants, so walk drops there.
   always_comb begin
      lamp_d = {state_d == S_RED, state_d == S_YEL, state_d == S_GRN};
      sc_d   = adv;
      ack_d  = grant;
      walk_d = adv ? grant : walk_q;
   end

   assign {lamp_red_o, lamp_yel_o, lamp_grn_o} = lamp_q;
   assign state_o        = state_q;
   assign state_change_o = sc_q;
   assign walk_o         = walk_q;
   assign ped_ack_o      = ack_q;

endmodule
